// File: rtl/sift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sift_pkg
//  Description : Shared constants, octant encoding and sub-bin rounding
//                thresholds for the orientation quantiser.
//  Revision    : 1.0 - initial release
// ============================================================================
package sift_pkg;

    localparam int c_nbins_min = 8;
    localparam int c_nbins_max = 64;
    localparam int c_tan_frac  = 16;

    typedef struct packed {
        logic neg_x;
        logic neg_y;
        logic swap;
    } octant_t;

    function automatic int sub_width(input int bin_w);
        return (bin_w > 3) ? bin_w - 3 : 1;
    endfunction

    // Q16 tangent of the j-th half-bin boundary inside the first octant.
    // Table is in units of pi/64; coarser bin counts step through it.
    function automatic logic [c_tan_frac:0] half_bin_tan(input int nbins, input int j);
        int n;
        int k;
        n = (nbins < c_nbins_min) ? c_nbins_min : nbins;
        k = (2 * j + 1) * (c_nbins_max / n);
        case (k)
            1:       return 17'd3220;
            2:       return 17'd6455;
            3:       return 17'd9721;
            4:       return 17'd13036;
            5:       return 17'd16416;
            6:       return 17'd19880;
            7:       return 17'd23449;
            8:       return 17'd27146;
            9:       return 17'd30996;
            10:      return 17'd35030;
            11:      return 17'd39282;
            12:      return 17'd43790;
            13:      return 17'd48603;
            14:      return 17'd53784;
            15:      return 17'd59398;
            default: return 17'd65536;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dir_octant_lut.sv
`default_nettype none
// ============================================================================
//  Module      : dir_octant_lut
//  Description : First-octant sub-bin lookup; addr = {min magnitude, max magnitude}.
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_octant_lut
    import sift_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int NBINS   = 32,
    parameter int BIN_W   = $clog2(NBINS)
) (
    input  logic [2*(COORD_W+1)-1:0]   addr,
    output logic [sub_width(BIN_W)-1:0] sub,
    output logic                        carry
);

    localparam int c_sub_w = sub_width(BIN_W);
    localparam int c_mw    = COORD_W + 1;
    localparam int c_pw    = c_mw + c_tan_frac + 1;

    logic [c_mw-1:0]  w_a;
    logic [c_mw-1:0]  w_b;
    logic [c_pw-1:0]  w_lhs;
    logic [c_sub_w:0] w_cnt;

    assign w_b = addr[2*c_mw-1:c_mw];
    assign w_a = addr[c_mw-1:0];

    // Rounded sub-bin = number of half-bin boundaries the slope b/a reaches.
    always_comb begin
        w_lhs = c_pw'(w_b) << c_tan_frac;
        w_cnt = '0;
        for (int j = 0; j < NBINS / 8; j++) begin
            if (w_lhs >= c_pw'(w_a) * c_pw'(half_bin_tan(NBINS, j)))
                w_cnt = w_cnt + (c_sub_w + 1)'(1);
        end
    end

    // carry marks a round-up onto the octant boundary itself
    assign sub   = w_cnt[c_sub_w-1:0];
    assign carry = w_cnt[c_sub_w];

endmodule
`default_nettype wire

// File: rtl/dir_quant_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dir_quant_pipe
//  Description : 3-stage gradient orientation quantiser with keypoint rotation.
//                Optional magnitude output enabled by macro DIR_QUANT_MAG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_quant_pipe
    import sift_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int NBINS   = 32,
    parameter int BIN_W   = $clog2(NBINS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] dx,
    input  logic [COORD_W-1:0] dy,
    input  logic [BIN_W-1:0]   rot,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIN_W-1:0]   bin,
`ifdef DIR_QUANT_MAG_EN
    output logic [COORD_W:0]   mag,
`endif
    output logic               zero
);

    localparam int c_sub_w = sub_width(BIN_W);
    localparam int c_mw    = COORD_W + 1;
    localparam logic [BIN_W-1:0] c_quarter = BIN_W'(NBINS / 4);
    localparam logic [BIN_W-1:0] c_half    = BIN_W'(NBINS / 2);

    logic w_adv1, w_adv2, w_adv3;
    logic r1_v, r2_v;

    assign w_adv3   = !out_valid || out_ready;
    assign w_adv2   = !r2_v || w_adv3;
    assign w_adv1   = !r1_v || w_adv2;
    assign in_ready = w_adv1;

    // S1: magnitudes in one extra bit so the most negative input folds cleanly
    logic [c_mw-1:0] w_dx_ext, w_dy_ext, w_ax, w_ay, w_a, w_b;
    octant_t         w_oct;
    logic            w_zero;

    assign w_dx_ext     = {dx[COORD_W-1], dx};
    assign w_dy_ext     = {dy[COORD_W-1], dy};
    assign w_ax         = dx[COORD_W-1] ? -w_dx_ext : w_dx_ext;
    assign w_ay         = dy[COORD_W-1] ? -w_dy_ext : w_dy_ext;
    assign w_oct.neg_x  = dx[COORD_W-1];
    assign w_oct.neg_y  = dy[COORD_W-1];
    assign w_oct.swap   = (w_ay > w_ax);
    assign w_a          = w_oct.swap ? w_ay : w_ax;
    assign w_b          = w_oct.swap ? w_ax : w_ay;
    assign w_zero       = (dx == '0) && (dy == '0);

    octant_t          r1_oct, r2_oct;
    logic [c_mw-1:0]  r1_a, r1_b;
    logic             r1_zero, r2_zero;
    logic [BIN_W-1:0] r1_rot, r2_rot;
    logic [c_sub_w:0] r2_q;

    // S2: sub-bin lookup
    logic [c_sub_w-1:0] w_sub;
    logic               w_carry;

    dir_octant_lut #(
        .COORD_W (COORD_W),
        .NBINS   (NBINS),
        .BIN_W   (BIN_W)
    ) u_lut (
        .addr  ({r1_b, r1_a}),
        .sub   (w_sub),
        .carry (w_carry)
    );

    // S3: mirror within the quadrant, then into the full circle, then rotate
    logic [BIN_W-1:0] w_q, w_qb, w_raw, w_bin;

    assign w_q  = BIN_W'(r2_q);
    assign w_qb = r2_oct.swap ? c_quarter - w_q : w_q;

    always_comb begin
        w_raw = w_qb;
        case ({r2_oct.neg_x, r2_oct.neg_y})
            2'b00:   w_raw = w_qb;
            2'b10:   w_raw = c_half - w_qb;
            2'b11:   w_raw = c_half + w_qb;
            default: w_raw = -w_qb;
        endcase
        if (r2_zero)
            w_raw = '0;
    end

    assign w_bin = w_raw - r2_rot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_v      <= 1'b0;
            r2_v      <= 1'b0;
            out_valid <= 1'b0;
            r1_oct    <= '0;
            r1_a      <= '0;
            r1_b      <= '0;
            r1_zero   <= 1'b0;
            r1_rot    <= '0;
            r2_oct    <= '0;
            r2_q      <= '0;
            r2_zero   <= 1'b0;
            r2_rot    <= '0;
            bin       <= '0;
            zero      <= 1'b0;
        end else begin
            if (w_adv1) begin
                r1_v <= in_valid;
                if (in_valid) begin
                    r1_oct  <= w_oct;
                    r1_a    <= w_a;
                    r1_b    <= w_b;
                    r1_zero <= w_zero;
                    r1_rot  <= rot;
                end
            end
            if (w_adv2) begin
                r2_v <= r1_v;
                if (r1_v) begin
                    r2_oct  <= r1_oct;
                    r2_q    <= {w_carry, w_sub};
                    r2_zero <= r1_zero;
                    r2_rot  <= r1_rot;
                end
            end
            if (w_adv3) begin
                out_valid <= r2_v;
                if (r2_v) begin
                    bin  <= w_bin;
                    zero <= r2_zero;
                end
            end
        end
    end

`ifdef DIR_QUANT_MAG_EN
    // max + min/2 approximation, saturated to the output width
    logic [c_mw:0]   w_mag_sum;
    logic [c_mw-1:0] w_mag, r1_mag, r2_mag;

    assign w_mag_sum = {1'b0, w_a} + {2'b00, w_b[c_mw-1:1]};
    assign w_mag     = w_mag_sum[c_mw] ? '1 : w_mag_sum[c_mw-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_mag <= '0;
            r2_mag <= '0;
            mag    <= '0;
        end else begin
            if (w_adv1 && in_valid)
                r1_mag <= w_mag;
            if (w_adv2 && r1_v)
                r2_mag <= r1_mag;
            if (w_adv3 && r2_v)
                mag <= r2_mag;
        end
    end
`endif

endmodule
`default_nettype wire
